// File: rtl/uart_pkg.sv
// Shared UART types, constants and helpers for uart_tx / uart_rx.
// Parity support in uart_tx is enabled with UART_TX_PARITY_EN.
`timescale 1ns/1ps
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  function automatic int calc_clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: one-cycle tick on the last clock of each bit.
// Synchronous clear re-aligns the phase at the start of a frame.
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en && w_last;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, stop bit(s).
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
`timescale 1ns/1ps
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int CLKS_PER_BIT =
    calc_clks_per_bit(CLK_FREQ, BAUD_RATE);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  uart_tx_state_t            r_state;
  uart_tx_state_t            w_state_next;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_next;
  logic [2:0]                r_bit_idx;
  logic [2:0]                w_bit_next;
  logic                      r_tx;
  logic                      w_tx_next;
  logic                      r_ready;
  logic                      r_busy;
  logic                      w_accept;
  logic                      w_tick;

  assign w_accept = data_valid && r_ready;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_accept),
    .i_en   (r_busy),
    .o_tick (w_tick)
  );

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^data;
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_bit_next   = r_bit_idx;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = START;
          w_shift_next = data;
          w_bit_next   = '0;
        end
      end
      START: begin
        if (w_tick) w_state_next = DATA;
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
            w_bit_next = '0;
          end else begin
            w_bit_next   = r_bit_idx + 3'd1;
            w_shift_next = r_shift >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_tick) w_state_next = STOP;
      end
`endif
      STOP: begin
        // Bit index doubles as the stop-bit counter.
        if (w_tick) begin
          if (r_bit_idx == 3'(STOP_BITS - 1)) begin
            w_state_next = IDLE;
            w_bit_next   = '0;
          end else begin
            w_bit_next = r_bit_idx + 3'd1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // tx is registered from the next state so the line never glitches.
  always_comb begin
    w_tx_next = UART_IDLE_LEVEL;
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_next = r_parity;
`endif
      default: w_tx_next = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= UART_IDLE_LEVEL;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_next;
      r_tx      <= w_tx_next;
      r_ready   <= (w_state_next == IDLE);
      r_busy    <= (w_state_next != IDLE);
    end
  end

  assign ready = r_ready;
  assign tx    = r_tx;
  assign busy  = r_busy;

endmodule
